// File: rtl/life_frame_streamer.sv
// rtl/life_frame_streamer.sv - snapshots a Life grid and streams it one row per beat
// Also accumulates the live-cell population and counts completed frames.
module life_frame_streamer #(
  parameter int M  = 64,
  parameter int N  = 64,
  parameter int RW = $clog2(N),
  parameter int PW = $clog2(M*N+1)
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic [N*M-1:0] state_i,
  input  logic           start_i,
  input  logic           out_ready_i,
  output logic           out_valid_o,
  output logic [M-1:0]   out_data_o,
  output logic [RW-1:0]  out_row_o,
  output logic           out_last_o,
  output logic           busy_o,
  output logic           frame_drop_o,
  output logic           pop_valid_o,
  output logic [PW-1:0]  pop_count_o,
  output logic [15:0]    frame_count_o
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} fsm_t;

  fsm_t           fsm_q;
  logic [N*M-1:0] frame_q;
  logic [RW-1:0]  row_q;
  logic [PW-1:0]  acc_q;
  logic           valid_q;
  logic           last_q;
  logic           busy_q;
  logic           drop_q;
  logic           pop_valid_q;
  logic [PW-1:0]  pop_count_q;
  logic [15:0]    frame_count_q;

  logic [RW-1:0]  next_row;
  logic [PW-1:0]  acc_next;

  function automatic logic [PW-1:0] popcount(input logic [M-1:0] bits);
    logic [PW-1:0] sum;
    sum = '0;
    for (int i = 0; i < M; i++) begin
      sum = sum + PW'(bits[i]);
    end
    return sum;
  endfunction

  // Beat data comes only from the captured frame, never from state_i.
  assign out_data_o = frame_q[row_q*M +: M];
  assign next_row   = row_q + RW'(1);
  assign acc_next   = acc_q + popcount(out_data_o);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fsm_q         <= IDLE;
      frame_q       <= '0;
      row_q         <= '0;
      acc_q         <= '0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      busy_q        <= 1'b0;
      drop_q        <= 1'b0;
      pop_valid_q   <= 1'b0;
      pop_count_q   <= '0;
      frame_count_q <= '0;
    end else begin
      drop_q      <= start_i && (fsm_q != IDLE);
      pop_valid_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (start_i) begin
            frame_q <= state_i;
            row_q   <= '0;
            acc_q   <= '0;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            busy_q  <= 1'b1;
            fsm_q   <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready_i) begin
            acc_q <= acc_next;
            if (last_q) begin
              // Publish on the DONE cycle so the count includes the final row.
              valid_q       <= 1'b0;
              last_q        <= 1'b0;
              pop_valid_q   <= 1'b1;
              pop_count_q   <= acc_next;
              frame_count_q <= frame_count_q + 16'd1;
              fsm_q         <= DONE;
            end else begin
              row_q  <= next_row;
              last_q <= (next_row == RW'(N-1));
            end
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          fsm_q  <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign out_valid_o   = valid_q;
  assign out_row_o     = row_q;
  assign out_last_o    = last_q;
  assign busy_o        = busy_q;
  assign frame_drop_o  = drop_q;
  assign pop_valid_o   = pop_valid_q;
  assign pop_count_o   = pop_count_q;
  assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_life_frame_streamer.sv
// tb/tb_life_frame_streamer.sv - self-checking bench for life_frame_streamer
module tb_life_frame_streamer;
  localparam int M  = 8;
  localparam int N  = 4;
  localparam int RW = $clog2(N);
  localparam int PW = $clog2(M*N+1);

  logic           clk = 1'b0;
  logic           reset_i;
  logic [N*M-1:0] state_i;
  logic           start_i;
  logic           out_ready_i;
  logic           out_valid_o;
  logic [M-1:0]   out_data_o;
  logic [RW-1:0]  out_row_o;
  logic           out_last_o;
  logic           busy_o;
  logic           frame_drop_o;
  logic           pop_valid_o;
  logic [PW-1:0]  pop_count_o;
  logic [15:0]    frame_count_o;

  life_frame_streamer #(.M(M), .N(N)) dut (
    .clk_i(clk), .reset_i(reset_i), .state_i(state_i), .start_i(start_i),
    .out_ready_i(out_ready_i), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
    .out_row_o(out_row_o), .out_last_o(out_last_o), .busy_o(busy_o),
    .frame_drop_o(frame_drop_o), .pop_valid_o(pop_valid_o),
    .pop_count_o(pop_count_o), .frame_count_o(frame_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [M-1:0]  data;
    logic [RW-1:0] row;
    logic          last;
  } beat_t;

  typedef struct {
    logic [N*M-1:0] grid;
    logic [PW-1:0]  pop;
  } vec_t;

  beat_t         beat_q[$];
  logic [PW-1:0] pop_q[$];
  beat_t         mb;
  vec_t          vecs[6];
  int            n_cmp = 0;
  int            n_err = 0;
  int            exp_frames = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [N*M-1:0] g);
    beat_t b;
    for (int r = 0; r < N; r++) begin
      b.data = g[r*M +: M];
      b.row  = RW'(r);
      b.last = (r == N-1);
      beat_q.push_back(b);
    end
    pop_q.push_back(PW'($countones(g)));
  endtask

  task automatic start_frame(input logic [N*M-1:0] g);
    state_i = g;
    start_i = 1'b1;
    push_frame(g);
    tick();
    start_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    start_i = 1'b0;
    out_ready_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    beat_q.delete();
    pop_q.delete();
    exp_frames = 0;
  endtask

  // Scoreboard: compare every transferred beat and every frame completion.
  always @(negedge clk) begin
    if (!reset_i && out_valid_o && out_ready_i) begin
      if (beat_q.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        mb = beat_q.pop_front();
        check("beat_data", out_data_o, mb.data);
        check("beat_row", out_row_o, mb.row);
        check("beat_last", out_last_o, mb.last);
      end
    end
    if (pop_valid_o) begin
      exp_frames = (exp_frames + 1) & 16'hFFFF;
      check("frame_count", frame_count_o, exp_frames);
      if (pop_q.size() == 0) check("unexpected_pop", 64'd1, 64'd0);
      else check("pop_count_sb", pop_count_o, pop_q.pop_front());
    end
  end

  initial begin
    vecs[0] = '{32'h0004060C, 6'd5};
    vecs[1] = '{32'hFFFFFFFF, 6'd32};
    vecs[2] = '{32'h00000000, 6'd0};
    vecs[3] = '{32'h80000001, 6'd2};
    vecs[4] = '{32'hA5A55A5A, 6'd16};
    vecs[5] = '{32'h01020408, 6'd4};

    reset_i = 1'b1;
    start_i = 1'b0;
    out_ready_i = 1'b1;
    state_i = '0;
    for (int i = 0; i < 2; i++) begin
      state_i = $urandom;
      start_i = 1'($urandom_range(0, 1));
      tick();
    end
    check("rst_valid", out_valid_o, 0);
    check("rst_data", out_data_o, 0);
    check("rst_row", out_row_o, 0);
    check("rst_last", out_last_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_drop", frame_drop_o, 0);
    check("rst_pop_valid", pop_valid_o, 0);
    check("rst_pop_count", pop_count_o, 0);
    check("rst_frame_count", frame_count_o, 0);
    do_reset();

    // Table: back-to-back frames at the minimum period with ready held high.
    for (int v = 0; v < 6; v++) begin
      start_frame(vecs[v].grid);
      check("tbl_busy_t1", busy_o, 1);
      check("tbl_valid_t1", out_valid_o, 1);
      check("tbl_row_t1", out_row_o, 0);
      check("tbl_last_t1", out_last_o, 0);
      tick(); tick(); tick();
      check("tbl_last_t4", out_last_o, 1);
      check("tbl_row_t4", out_row_o, N-1);
      tick();
      check("tbl_pop_valid_t5", pop_valid_o, 1);
      check("tbl_pop_count_t5", pop_count_o, vecs[v].pop);
      check("tbl_valid_t5", out_valid_o, 0);
      check("tbl_busy_t5", busy_o, 1);
      tick();
      check("tbl_busy_t6", busy_o, 0);
      check("tbl_pop_valid_t6", pop_valid_o, 0);
      check("tbl_drop", frame_drop_o, 0);
    end
    check("tbl_frames", frame_count_o, 6);

    // Backpressure on row 1 and snapshot isolation.
    do_reset();
    start_frame(32'h0004060C);
    state_i = '1;
    tick();
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", out_valid_o, 1);
      check("bp_data", out_data_o, 8'h06);
      check("bp_row", out_row_o, 1);
      tick();
    end
    out_ready_i = 1'b1;
    check("bp_row_release", out_row_o, 1);
    tick();
    tick();
    check("bp_pop_valid_t7", pop_valid_o, 0);
    check("bp_last_t7", out_last_o, 1);
    tick();
    check("bp_pop_valid_t8", pop_valid_o, 1);
    check("bp_pop_count_t8", pop_count_o, 5);
    tick();
    check("bp_busy_t9", busy_o, 0);

    // Full grid with a dropped start in DONE and an accepted start right after.
    do_reset();
    start_frame('1);
    tick(); tick(); tick(); tick();
    check("b2b_pop_valid1", pop_valid_o, 1);
    check("b2b_pop_count1", pop_count_o, 32);
    start_i = 1'b1;
    tick();
    check("b2b_drop_t6", frame_drop_o, 1);
    check("b2b_busy_t6", busy_o, 0);
    push_frame('1);
    tick();
    start_i = 1'b0;
    check("b2b_drop_t7", frame_drop_o, 0);
    check("b2b_busy_t7", busy_o, 1);
    check("b2b_row_t7", out_row_o, 0);
    tick(); tick(); tick(); tick();
    check("b2b_pop_valid2", pop_valid_o, 1);
    check("b2b_pop_count2", pop_count_o, 32);
    check("b2b_frames", frame_count_o, 2);
    tick();

    // Start while busy is dropped and the stream is unaltered.
    do_reset();
    start_frame(32'h80C0E0F0);
    tick(); tick();
    check("sb_row2", out_row_o, 2);
    state_i = 32'h0F0F0F0F;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("sb_drop", frame_drop_o, 1);
    check("sb_row3", out_row_o, 3);
    tick();
    check("sb_drop_once", frame_drop_o, 0);
    check("sb_pop_valid", pop_valid_o, 1);
    check("sb_pop_count", pop_count_o, 10);
    tick();
    check("sb_busy", busy_o, 0);
    tick();
    check("sb_frames", frame_count_o, 1);

    // Reset while row 2 is presented discards the frame.
    do_reset();
    start_frame(32'h12345678);
    tick(); tick();
    check("rm_row2", out_row_o, 2);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    beat_q.delete();
    pop_q.delete();
    exp_frames = 0;
    check("rm_valid", out_valid_o, 0);
    check("rm_busy", busy_o, 0);
    check("rm_frames", frame_count_o, 0);
    check("rm_pop_count", pop_count_o, 0);
    check("rm_row", out_row_o, 0);
    start_frame(32'hDEADBEEF);
    check("rm_fresh_row0", out_row_o, 0);
    check("rm_fresh_valid", out_valid_o, 1);
    tick(); tick(); tick(); tick();
    check("rm_fresh_pop_valid", pop_valid_o, 1);
    check("rm_fresh_pop_count", pop_count_o, 24);
    check("rm_fresh_frames", frame_count_o, 1);
    tick(); tick();

    check("sb_beats_left", beat_q.size(), 0);
    check("sb_pops_left", pop_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
